lfsr_arb_ctrl: RTL
==================

LFSR_ARB_CTRL -- requirements
Module: lfsr_arb_ctrl

Interface
REQ-001 Parameter N_STEPS, default 8, SHALL set LFSR shifts per delivered word; legal range 1..255.
REQ-002 Parameter DEFAULT_SEED, default 64'h0000_0000_0000_0001, SHALL be the reset/substitute LFSR value.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be synchronous, active-low (reset==0 at a rising edge resets).
REQ-005 seed_in  in  64  SHALL be the seed value, sampled when seed_load is accepted.
REQ-006 seed_load  in  1  SHALL be a seed load request, one-cycle pulse.
REQ-007 req  in  2  SHALL be per-requester word requests, held high until served.
REQ-008 gnt  out  2  SHALL be one-hot grant, or 0 when idle.
REQ-009 valid  out  1  SHALL be high for exactly one cycle when rnd_out is delivered.
REQ-010 rnd_out  out  64  SHALL be the delivered random word.
REQ-011 busy  out  1  SHALL be high in RUN and DONE.
REQ-012 seed_err  out  1  SHALL be a sticky flag for a rejected lock-up seed.
REQ-013 seed_ign  out  1  SHALL pulse one cycle when seed_load is ignored.

Function
REQ-014 Internal 64-bit LFSR q shift SHALL be: q <= {q[62:0], ~(q[63]^q[62]^q[60]^q[59])}.
REQ-015 q SHALL shift only in RUN, one shift per cycle; it SHALL hold in all other states.
REQ-016 FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-017 In IDLE, seed_load==1 SHALL take priority over req: next state LOAD, seed_in captured into a holding register.
REQ-018 In LOAD, q SHALL be set to the captured seed, unless the seed is 64'hFFFF_FFFF_FFFF_FFFF (lock-up).
REQ-019 For a lock-up seed, LOAD SHALL set q to DEFAULT_SEED and set seed_err=1; the next state SHALL be IDLE.
REQ-020 In IDLE with no seed_load and req!=0, the arbiter SHALL grant one requester: gnt registered, cnt<=0, next state RUN.
REQ-021 Arbitration SHALL be round-robin: if both request, grant the requester not granted last; if one requests, grant it.
REQ-022 In RUN, cnt SHALL increment per shift; after the N_STEPS-th shift (cnt==N_STEPS-1), next state SHALL be DONE.
REQ-023 In DONE, valid=1 and rnd_out=q SHALL hold for one cycle with gnt unchanged; next state IDLE, with gnt<=0 and valid<=0.
REQ-024 valid SHALL rise N_STEPS+1 edges after the edge at which IDLE accepted the request.
REQ-025 rnd_out SHALL hold its last delivered value outside DONE.
REQ-026 Dropping req during RUN SHALL NOT abort the run; the word is still delivered with valid and gnt.
REQ-027 seed_load in LOAD/RUN/DONE SHALL be ignored (not queued) and SHALL pulse seed_ign the next cycle.
REQ-028 The last-granted pointer SHALL update only on grant, so each requester gets at most one consecutive word under contention.
REQ-029 busy SHALL equal (state==RUN || state==DONE).

Reset
REQ-030 Reset SHALL force: state IDLE, q=DEFAULT_SEED, cnt=0, gnt=0, valid=0, rnd_out=0, seed_err=0, seed_ign=0, busy=0.
REQ-031 Reset SHALL set the last-granted pointer to requester 1, so req[0] wins the first contention.
REQ-032 Reset SHALL override any state mid-run; no valid SHALL follow a run aborted by reset.
REQ-033 seed_err SHALL be cleared only by reset.

Verification
REQ-034 Reset, then req=2'b01 held, N_STEPS=8 -> gnt=01; valid pulses once with rnd_out=64'h0000_0000_0000_01FF, 9 edges after acceptance.
REQ-035 seed_load with seed_in=64'h8000_0000_0000_0000, then req=01, N_STEPS=1 -> rnd_out=64'h0000_0000_0000_0000 (feedback 0).
REQ-036 req=2'b11 held continuously from reset -> grants alternate 01,10,01,10; consecutive words continue one LFSR sequence.
REQ-037 seed_load with all-ones seed -> seed_err=1 sticky; next word equals the DEFAULT_SEED result (64'h1FF for N_STEPS=8).
REQ-038 seed_load pulsed during RUN -> seed_ign pulses one cycle; delivered word unaffected.
REQ-039 reset=0 asserted mid-RUN -> all outputs at reset values next cycle; no valid pulse afterward without a new req.

Source files
------------

// File: rtl/lfsr_arb_ctrl.sv
// Two-requester round-robin front end for a 64-bit LFSR random-word generator.
// Each granted request runs N_STEPS shifts, then delivers one word with a single-cycle valid.
module lfsr_arb_ctrl #(
  parameter int unsigned N_STEPS      = 8,
  parameter logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] seed_in,
  input  logic        seed_load,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        valid,
  output logic [63:0] rnd_out,
  output logic        busy,
  output logic        seed_err,
  output logic        seed_ign
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [7:0]  LAST_CNT = 8'(N_STEPS - 1);
  localparam logic [63:0] LOCKUP   = 64'hFFFF_FFFF_FFFF_FFFF;

  state_e      state_q, state_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic [63:0] hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic [63:0] rnd_q, rnd_d;
  logic        err_q, err_d;
  logic        ign_q, ign_d;
  logic        pick_s;

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return {v[62:0], ~(v[63] ^ v[62] ^ v[60] ^ v[59])};
  endfunction

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    rnd_d   = rnd_q;
    err_d   = err_q;
    valid_d = 1'b0;
    ign_d   = 1'b0;
    pick_s  = 1'b0;
    // Grant is held through the valid cycle and dropped on the edge after it
    if (valid_q) begin
      gnt_d = 2'b00;
    end else begin
      gnt_d = gnt_q;
    end
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          hold_d  = seed_in;
          state_d = LOAD;
        end else if ((req != 2'b00) && !valid_q) begin
          if (req == 2'b11) begin
            pick_s = ~last_q;
          end else begin
            pick_s = req[1];
          end
          gnt_d   = pick_s ? 2'b10 : 2'b01;
          last_d  = pick_s;
          cnt_d   = 8'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        ign_d = seed_load;
        if (hold_q == LOCKUP) begin
          lfsr_d = DEFAULT_SEED;
          err_d  = 1'b1;
        end else begin
          lfsr_d = hold_q;
        end
        state_d = IDLE;
      end
      RUN: begin
        ign_d  = seed_load;
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        ign_d   = seed_load;
        valid_d = 1'b1;
        rnd_d   = lfsr_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= DEFAULT_SEED;
      hold_q  <= 64'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      rnd_q   <= 64'd0;
      err_q   <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      rnd_q   <= rnd_d;
      err_q   <= err_d;
      ign_q   <= ign_d;
    end
  end

  assign gnt      = gnt_q;
  assign valid    = valid_q;
  assign rnd_out  = rnd_q;
  assign busy     = (state_q == RUN) || (state_q == DONE);
  assign seed_err = err_q;
  assign seed_ign = ign_q;

endmodule
